// File: rtl/mem_response_merger.sv
// mem_response_merger
// Pairs issued AXI write requests (possibly split at a 4KB boundary into two
// halves) with their B-channel responses and emits exactly one merged
// completion per original request. A small descriptor FIFO remembers, in
// issue order, whether each request was split, so the FSM knows whether to
// wait for one or two B responses before reporting completion.

module mem_response_merger #(
  parameter int DEPTH      = 4,
  parameter int RESP_WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         desc_valid,
  input  logic                         desc_split,
  output logic                         desc_ready,
  input  logic                         bvalid,
  input  logic [RESP_WIDTH-1:0]        bresp,
  output logic                         bready,
  output logic                         done_valid,
  output logic [RESP_WIDTH-1:0]        done_resp,
  output logic                         done_split,
  input  logic                         done_ready,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding,
  output logic                         merger_idle
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    MRG_IDLE   = 2'd0,
    MRG_WAIT_A = 2'd1,
    MRG_WAIT_B = 2'd2,
    MRG_DONE   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DEPTH-1:0]      split_mem_q, split_mem_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [RESP_WIDTH-1:0] resp_q, resp_d;

  logic push;
  logic pop;
  logic full;
  logic empty;
  logic head_split;

  // FIFO status and handshakes. The head is retired only from MRG_DONE when
  // the consumer takes the completion; a retiring slot may be refilled in the
  // same cycle, so a full FIFO still accepts a descriptor while it pops.
  always_comb begin
    full       = (count_q == CNT_W'(DEPTH));
    empty      = (count_q == '0);
    pop        = (state_q == MRG_DONE) && done_ready;
    desc_ready = !full || pop;
    push       = desc_valid && desc_ready;
    head_split = split_mem_q[rd_ptr_q];
  end

  // Descriptor FIFO next-state: write at wr_ptr, retire at rd_ptr, both
  // wrapping naturally because DEPTH is a power of two.
  always_comb begin
    split_mem_d = split_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (push) begin
      split_mem_d[wr_ptr_q] = desc_split;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Merge FSM: waits for one or two B responses for the head descriptor,
  // keeps the most severe code, then presents a single completion.
  always_comb begin
    state_d    = state_q;
    resp_d     = resp_q;
    bready     = 1'b0;
    done_valid = 1'b0;
    done_resp  = '0;
    done_split = 1'b0;
    unique case (state_q)
      MRG_IDLE: begin
        if (!empty) begin
          state_d = MRG_WAIT_A;
        end
      end
      MRG_WAIT_A: begin
        bready = !empty;
        if (bvalid && !empty) begin
          resp_d  = bresp;
          state_d = head_split ? MRG_WAIT_B : MRG_DONE;
        end
      end
      MRG_WAIT_B: begin
        bready = !empty;
        if (bvalid && !empty) begin
          if (bresp > resp_q) begin
            resp_d = bresp;
          end
          state_d = MRG_DONE;
        end
      end
      MRG_DONE: begin
        done_valid = 1'b1;
        done_resp  = resp_q;
        done_split = head_split;
        if (done_ready) begin
          state_d = MRG_IDLE;
        end
      end
      default: begin
        state_d = MRG_IDLE;
      end
    endcase
  end

  // Status outputs derived directly from registered state.
  always_comb begin
    outstanding = count_q;
    merger_idle = (state_q == MRG_IDLE) && empty;
  end

  // State registers; reset discards any in-flight merge and all descriptors.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= MRG_IDLE;
      split_mem_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      resp_q      <= '0;
    end else begin
      state_q     <= state_d;
      split_mem_q <= split_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      resp_q      <= resp_d;
    end
  end

endmodule
